fifo_rd_serializer: RTL and testbench
=====================================

FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

Interface
REQ-001 Parameter DIV, default 4: clock cycles per serial bit period; legal range 2..255.
REQ-002 Parameter DATA_W, default 5: FIFO word width.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port enable, input, 1: permits starting new frames.
REQ-006 Port empty, input, 1: FIFO empty flag.
REQ-007 Port ren, output, 1: FIFO read strobe; at most one cycle wide per frame.
REQ-008 Port fifo_dout, input, DATA_W: FIFO read data; valid in the cycle after the ren edge.
REQ-009 Port tx, output, 1: serial line; idle high.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port frames_sent, output, 8: count of completed frames.

Function
REQ-012 The block SHALL be the sole reader of its FIFO; empty can only be cleared by an external write.
REQ-013 States SHALL be IDLE, REQ, CAP, START, DATA, STOP.
REQ-014 IDLE -> REQ when enable=1 and empty=0; otherwise remain in IDLE.
REQ-015 ren SHALL be 1 exactly in REQ; REQ -> CAP unconditionally after one cycle.
REQ-016 In CAP, fifo_dout SHALL be latched into a DATA_W shift register; CAP -> START after one cycle.
REQ-017 START SHALL drive tx=0 for DIV cycles, then enter DATA with bit index 0.
REQ-018 DATA SHALL drive shift register bit 0 (LSB first) for DIV cycles per bit over DATA_W bits, then enter STOP.
REQ-019 STOP SHALL drive tx=1 for DIV cycles, then increment frames_sent (8-bit, 255 wraps to 0) and enter IDLE.
REQ-020 tx SHALL be registered and equal 1 in IDLE, REQ and CAP.
REQ-021 Frame length SHALL be (DATA_W+2)*DIV cycles; gap between back-to-back frames SHALL be exactly 3 cycles (IDLE, REQ, CAP).
REQ-022 enable and empty SHALL be sampled only in IDLE; deasserting enable mid-frame SHALL let the current frame complete.
REQ-023 ren SHALL never be asserted while empty=1 is sampled in the same IDLE decision cycle.
REQ-024 Bit timer SHALL count 0..DIV-1 and reload 0 on every state transition.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, tx=1, ren=0, busy=0, frames_sent=0, bit timer=0, bit index=0, shift register=0.
REQ-026 rst mid-frame SHALL abort the frame without incrementing frames_sent; the aborted word is lost.
REQ-027 rst SHALL take priority over all other inputs.

Structure
REQ-028 A shared package SHALL hold the state encoding, DATA_W default and FRAME_BITS=DATA_W+2.
REQ-029 The bit timer SHALL be a sub-module named bit_timer (inputs clock, rst, clear; output tick at count DIV-1).
REQ-030 All outputs SHALL be driven by registers except ren, which decodes state directly.

Verification
REQ-031 DIV=4, FIFO holds 5'b10110, enable=1 -> one ren pulse; tx = 0,0,1,1,0,1,1 bit periods, 4 cycles each; frames_sent=1.
REQ-032 empty=1, enable=1 for 100 cycles -> ren never 1, tx=1, busy=0.
REQ-033 Three words 5'h01, 5'h1F, 5'h0A preloaded -> three frames, each 28 cycles, 3-cycle gaps, frames_sent=3.
REQ-034 rst asserted during DATA bit 2 -> next cycle tx=1, busy=0, frames_sent unchanged at 0; a new frame starts only after rst falls.
REQ-035 enable dropped during START with 2 words queued -> current frame completes; no further ren; frames_sent=1.
REQ-036 256 frames sent -> frames_sent wraps to 0.

Source files
------------

// File: rtl/fifo_rd_serializer_pkg.sv
// Shared definitions for the FIFO read serializer: state encoding and frame geometry.
package fifo_rd_serializer_pkg;

    // State encoding for the frame controller.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAP   = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    // Default FIFO word width.
    localparam int DATA_W_DEF = 5;

    // Bit periods per frame at the default width: start + data + stop.
    localparam int FRAME_BITS = DATA_W_DEF + 2;

endpackage

// File: rtl/fifo_rd_serializer_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each period.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] TC = 8'(DIV - 1);

    logic [7:0] cnt;

    assign tick = (cnt == TC);

    // Free-running period counter, restarted whenever the controller changes state.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops one word from a FIFO and sends it as a start/data/stop serial frame, LSB first.
//
// state | meaning
// IDLE  | waiting for enable with a non-empty FIFO
// REQ   | one-cycle FIFO read strobe
// CAP   | latch FIFO read data into the shift register
// START | start bit (tx=0) for DIV cycles
// DATA  | DATA_W data bits, DIV cycles each
// STOP  | stop bit (tx=1) for DIV cycles, then count the frame
module fifo_rd_serializer
    import fifo_rd_serializer_pkg::*;
#(
    parameter int DIV    = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              enable,
    input  logic              empty,
    output logic              ren,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frames_sent
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nx;
    logic [7:0]        frames_nx;
    logic              tx_nx;
    logic              tick;
    logic              clear;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clock (clock),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // The read strobe is the only output decoded straight from state.
    assign ren = (state == S_REQ);

    // Next-state and datapath decode; tx and busy are precomputed from the next state
    // so their registers line up with the state they describe.
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        idx_nx    = idx;
        frames_nx = frames_sent;
        case (state)
            S_IDLE: begin
                if (enable && !empty) state_nx = S_REQ;
            end
            S_REQ: begin
                state_nx = S_CAP;
            end
            S_CAP: begin
                shreg_nx = fifo_dout;
                state_nx = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_nx = S_DATA;
                    idx_nx   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_STOP;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        shreg_nx = shreg >> 1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_nx  = S_IDLE;
                    frames_nx = frames_sent + 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        clear = (state_nx != state);

        case (state_nx)
            S_START: tx_nx = 1'b0;
            S_DATA:  tx_nx = shreg_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            idx         <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frames_sent <= 8'd0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            idx         <= idx_nx;
            tx          <= tx_nx;
            busy        <= (state_nx != S_IDLE);
            frames_sent <= frames_nx;
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench: FIFO model feeds the serializer, a scoreboard holds the words
// expected on tx and a frame receiver decodes and compares them.
module tb_fifo_rd_serializer;

    localparam int DIV = 4;
    localparam int DW  = 5;
    localparam int FRAME_CYC = (DW + 2) * DIV;

    logic          clock = 1'b0;
    logic          rst;
    logic          enable;
    logic          empty = 1'b1;
    logic          ren;
    logic [DW-1:0] fifo_dout = '0;
    logic          tx;
    logic          busy;
    logic [7:0]    frames_sent;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int ren_bad = 0;
    int last_end = -1;
    logic ren_d = 1'b0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    fifo_rd_serializer #(.DIV(DIV), .DATA_W(DW)) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .empty       (empty),
        .ren         (ren),
        .fifo_dout   (fifo_dout),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after the strobe edge.
    always @(posedge clock) begin
        ren_d <= ren;
        if (ren) begin
            ren_cnt <= ren_cnt + 1;
            if (ren_d) ren_bad <= ren_bad + 1;
            if (fifo_q.size() == 0) ren_bad <= ren_bad + 1;
            else fifo_dout <= fifo_q.pop_front();
        end
        empty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        last_end = -1;
    endtask

    // Waits for a start bit, samples every cycle of the frame and checks it.
    task automatic rx_frame(input string tag, input bit check_gap);
        int t;
        int bad;
        int start_cyc;
        logic [DW-1:0] got;
        logic [DW-1:0] exp;
        logic first;
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        start_cyc = cyc;
        if (check_gap && last_end >= 0) chk({tag, "_gap"}, 32'(start_cyc - last_end), 32'd3);
        bad = 0;
        got = '0;
        first = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            int p;
            p = i / DIV;
            if (busy !== 1'b1) bad++;
            if (p == 0) begin
                if (tx !== 1'b0) bad++;
            end else if (p <= DW) begin
                if (i % DIV == 0) begin
                    first = tx;
                    got[p-1] = tx;
                end else if (tx !== first) begin
                    bad++;
                end
            end else begin
                if (tx !== 1'b1) bad++;
            end
            @(negedge clock);
        end
        last_end = cyc;
        chk({tag, "_shape"}, 32'(bad), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_word"}, 32'(got), 32'(exp));
        end
    endtask

    initial begin
        int r0;
        int t;
        bit seen_ren;
        bit seen_low;
        bit seen_busy;

        enable = 1'b0;
        do_reset();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);

        // Empty FIFO with enable held: nothing must happen.
        enable = 1'b1;
        seen_ren = 0; seen_low = 0; seen_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ren) seen_ren = 1;
            if (tx !== 1'b1) seen_low = 1;
            if (busy) seen_busy = 1;
        end
        chk("empty_ren", 32'(seen_ren), 32'd0);
        chk("empty_tx", 32'(seen_low), 32'd0);
        chk("empty_busy", 32'(seen_busy), 32'd0);

        // Single word 10110.
        r0 = ren_cnt;
        push_word(5'b10110);
        rx_frame("single", 1'b0);
        wait_cyc(10);
        chk("single_ren_cnt", 32'(ren_cnt - r0), 32'd1);
        chk("single_frames", 32'(frames_sent), 32'd1);

        // Three preloaded words, back to back.
        enable = 1'b0;
        do_reset();
        push_word(5'h01);
        push_word(5'h1F);
        push_word(5'h0A);
        wait_cyc(3);
        enable = 1'b1;
        rx_frame("b2b0", 1'b0);
        rx_frame("b2b1", 1'b1);
        rx_frame("b2b2", 1'b1);
        wait_cyc(10);
        chk("b2b_frames", 32'(frames_sent), 32'd3);
        chk("b2b_busy", 32'(busy), 32'd0);

        // Reset during data bit 2 aborts the frame.
        do_reset();
        push_word(5'h15);
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin @(negedge clock); t++; end
        chk("abort_start_seen", 32'(t < 2000), 32'd1);
        wait_cyc(3 * DIV + 1);
        rst = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clock);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frames", 32'(frames_sent), 32'd0);
        r0 = ren_cnt;
        push_word(5'h0C);
        seen_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (busy || tx !== 1'b1) seen_busy = 1;
        end
        chk("abort_hold_idle", 32'(seen_busy), 32'd0);
        chk("abort_hold_ren", 32'(ren_cnt - r0), 32'd0);
        rst = 1'b0;
        last_end = -1;
        rx_frame("after_abort", 1'b0);
        chk("after_abort_frames", 32'(frames_sent), 32'd1);

        // Enable dropped during the start bit with two words queued.
        do_reset();
        r0 = ren_cnt;
        push_word(5'h13);
        push_word(5'h06);
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin @(negedge clock); t++; end
        enable = 1'b0;
        rx_frame("drop_en", 1'b0);
        wait_cyc(50);
        chk("drop_en_ren_cnt", 32'(ren_cnt - r0), 32'd1);
        chk("drop_en_frames", 32'(frames_sent), 32'd1);
        chk("drop_en_busy", 32'(busy), 32'd0);
        chk("drop_en_fifo_left", 32'(fifo_q.size()), 32'd1);
        exp_q.delete();
        fifo_q.delete();
        wait_cyc(2);

        // 256 frames: counter wraps to zero.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 256; i++) push_word(DW'($urandom_range(0, 31)));
        for (int i = 0; i < 256; i++) begin
            rx_frame("wrap", 1'b1);
            if (i == 254) chk("wrap_255", 32'(frames_sent), 32'd255);
            if (i == 255) chk("wrap_0", 32'(frames_sent), 32'd0);
        end

        chk("ren_protocol", 32'(ren_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
